cam_table_access_arbiter: RTL
=============================

Name: cam_table_access_arbiter

Overview:
- Shares the single 16-entry MAC CAM table between several requesters, typically one core_data_orchestrator per port group plus a management agent.
- Requesters issue learn (write MAC at address) or lookup (find address holding MAC) transactions; the block arbitrates round-robin, sequences CAM reads/writes, and returns one response per transaction.
- Sits between the orchestrators and the CAM table RAM; it is the only driver of the CAM table ports.

Parameters:
- NUMBER_OF_REQUESTERS, 2, number of requester channels (>=1).
- TABLE_DEPTH, 16, CAM entries scanned/writable (<= 2**ADDRESS_WIDTH).
- ADDRESS_WIDTH, 4, CAM address width.
- READ_LATENCY, 2, cycles from cam_table_read_address update to matching cam_table_read_data.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- request_valid  input  [NUMBER_OF_REQUESTERS]  per-requester transaction valid.
- request_write  input  [NUMBER_OF_REQUESTERS]  1 = learn, 0 = lookup.
- request_mac  input  [NUMBER_OF_REQUESTERS][48]  MAC to write or search.
- request_address  input  [NUMBER_OF_REQUESTERS][ADDRESS_WIDTH]  learn target address; ignored on lookup.
- request_ready  output  [NUMBER_OF_REQUESTERS]  one-hot accept, combinational.
- response_valid  output  [NUMBER_OF_REQUESTERS]  one-hot one-cycle response strobe to the owning requester.
- response_hit  output  1  lookup matched / learn performed.
- response_address  output  [ADDRESS_WIDTH]  matched or written address.
- table_clear  input  1  pulse: invalidate all entries.
- busy  output  1  high whenever state != S_IDLE.
- cam_table_read_address  output  [ADDRESS_WIDTH]  CAM read address.
- cam_table_read_data  input  48  CAM read data.
- cam_table_write_address  output  [ADDRESS_WIDTH]  CAM write address.
- cam_table_write_data  output  48  CAM write data.
- cam_table_write_data_valid  output  1  one-cycle write strobe.

Behaviour:
- Reset: all outputs 0, state S_IDLE, round-robin pointer 0, entry_valid bitmap all 0. Reset mid-transaction aborts it; no response is issued.
- Internal entry_valid[TABLE_DEPTH]: set on learn, cleared by table_clear. A lookup hit requires data equality and entry_valid.
- S_IDLE:
  - table_clear has priority. It clears entry_valid and no request is accepted that cycle.
  - Otherwise the round-robin winner among request_valid (search starts at pointer) gets request_ready=1. Fields are captured and the pointer becomes winner+1 (mod N).
  - Learn -> S_WRITE; lookup -> S_SCAN with cam_table_read_address<=0.
- S_WRITE (1 cycle):
  - If the address is < TABLE_DEPTH: write_address/data registered, write_data_valid=1, entry_valid set, hit=1.
  - Otherwise no write and hit=0.
  - -> S_RESPOND.
- S_SCAN:
  - Issue one address per cycle, 0..TABLE_DEPTH-1. A READ_LATENCY-deep tag pipe carries each address.
  - Compare each cam_table_read_data with its tag. On the first hit, capture the address, drop in-flight tags, and go to S_RESPOND with hit=1.
  - If the last tag compares without a hit -> S_RESPOND with hit=0 and address 0.
- S_RESPOND (1 cycle): response_valid[owner]=1 with hit/address held -> S_IDLE. The next accept is possible the following cycle.
- Latency (accept at cycle 0):
  - Learn: write strobe cycle 1, response cycle 2.
  - Lookup hit at entry k: response cycle 4+k.
  - Lookup miss: response cycle TABLE_DEPTH+3 (19 by default).
- table_clear outside S_IDLE is held pending and applied on return to S_IDLE, before arbitration. The transaction in progress completes against the old entry_valid.
- Only one transaction is in flight, so there is no read-during-write hazard.
- A requester dropping request_valid before ready is legal; it is simply not granted.

Decomposition:
- cam_arbiter_pkg: state enum (S_IDLE, S_WRITE, S_SCAN, S_RESPOND), MAC_WIDTH=48 constant, transaction-type typedef.
- Sub-module round_robin_arbiter: NUMBER_OF_REQUESTERS-wide request vector plus pointer in; one-hot grant plus grant index out; purely combinational.

Test Plan:
- Learn from requester 0: MAC 0x001122334455 at address 3 -> write strobe cycle 1 (addr 3, data 0x001122334455), response_valid=2'b01, hit=1, addr 3 at cycle 2.
- Lookup 0x001122334455 from requester 1 after that learn -> response_valid=2'b10, hit=1, addr 3 at cycle 7.
- Lookup 0x000000000000 on an empty table (CAM returns 0) -> hit=0 at cycle 19 (entry_valid gating).
- Both requesters valid every cycle, lookups -> grants alternate 0,1,0,1; each gets exactly one response per request.
- table_clear pulsed during the scan of a present MAC -> that lookup still hits. The next lookup of the same MAC misses.
- Reset asserted mid-scan (cycle 5) -> no response_valid, busy=0 the next cycle, a subsequent lookup misses.

Source files
------------

// File: rtl/cam_arbiter_pkg.sv
// Shared types for the CAM table access arbiter: FSM states, MAC width and
// transaction type.
package cam_arbiter_pkg;

  localparam int MAC_WIDTH = 48;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_SCAN    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  typedef enum logic {
    TXN_LOOKUP = 1'b0,
    TXN_LEARN  = 1'b1
  } txn_type_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request at or after pointer,
// wrapping modulo NUMBER_OF_REQUESTERS.
module round_robin_arbiter #(
  parameter int NUMBER_OF_REQUESTERS = 2,
  parameter int INDEX_WIDTH          = 1
) (
  input  logic [NUMBER_OF_REQUESTERS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]          pointer,
  output logic [NUMBER_OF_REQUESTERS-1:0] grant,
  output logic [INDEX_WIDTH-1:0]          grant_index,
  output logic                            grant_valid
);

  int                     candidate;
  logic [INDEX_WIDTH-1:0] candidate_index;

  always_comb begin
    grant           = '0;
    grant_index     = '0;
    grant_valid     = 1'b0;
    candidate       = 0;
    candidate_index = '0;
    for (int offset = 0; offset < NUMBER_OF_REQUESTERS; offset++) begin
      candidate = int'(pointer) + offset;
      if (candidate >= NUMBER_OF_REQUESTERS) candidate = candidate - NUMBER_OF_REQUESTERS;
      candidate_index = INDEX_WIDTH'(candidate);
      if (!grant_valid && request[candidate_index]) begin
        grant[candidate_index] = 1'b1;
        grant_index            = candidate_index;
        grant_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_table_access_arbiter.sv
// Arbitrates learn/lookup transactions from several requesters onto the single
// MAC CAM table; one transaction in flight, one response per transaction.
//
// Handshake: a request transfers in the cycle where request_valid[i] and
// request_ready[i] are both high; request_ready is one-hot, combinational, and
// only asserted in S_IDLE without a table_clear. A requester may drop valid at
// any time before it is granted. response_valid[owner] pulses for one cycle,
// with response_hit/response_address valid in that cycle.
module cam_table_access_arbiter
  import cam_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_REQUESTERS = 2,
  parameter int TABLE_DEPTH          = 16,
  parameter int ADDRESS_WIDTH        = 4,
  parameter int READ_LATENCY         = 2
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                request_valid,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                request_write,
  input  logic [NUMBER_OF_REQUESTERS-1:0][MAC_WIDTH-1:0] request_mac,
  input  logic [NUMBER_OF_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] request_address,
  output logic [NUMBER_OF_REQUESTERS-1:0]                request_ready,
  output logic [NUMBER_OF_REQUESTERS-1:0]                response_valid,
  output logic                                           response_hit,
  output logic [ADDRESS_WIDTH-1:0]                       response_address,
  input  logic                                           table_clear,
  output logic                                           busy,
  output logic [ADDRESS_WIDTH-1:0]                       cam_table_read_address,
  input  logic [MAC_WIDTH-1:0]                           cam_table_read_data,
  output logic [ADDRESS_WIDTH-1:0]                       cam_table_write_address,
  output logic [MAC_WIDTH-1:0]                           cam_table_write_data,
  output logic                                           cam_table_write_data_valid,
  output logic [1:0]                                     debug_state
);

  localparam int INDEX_WIDTH = (NUMBER_OF_REQUESTERS > 1) ? $clog2(NUMBER_OF_REQUESTERS) : 1;

  state_t                                     state_q, state_d;
  logic [INDEX_WIDTH-1:0]                     pointer_q;
  logic [NUMBER_OF_REQUESTERS-1:0]            owner_q;
  logic [MAC_WIDTH-1:0]                       mac_q;
  logic [TABLE_DEPTH-1:0]                     entry_valid_q;
  logic                                       clear_pending_q;
  logic                                       issuing_q;
  logic [READ_LATENCY-1:0]                    tag_valid_q;
  logic [READ_LATENCY-1:0][ADDRESS_WIDTH-1:0] tag_addr_q;

  logic [NUMBER_OF_REQUESTERS-1:0] grant;
  logic [INDEX_WIDTH-1:0]          grant_index;
  logic                            grant_valid;
  logic                            accept;
  txn_type_t                       txn_type;
  logic                            scan_hit;
  logic                            scan_last;

  round_robin_arbiter #(
    .NUMBER_OF_REQUESTERS(NUMBER_OF_REQUESTERS),
    .INDEX_WIDTH         (INDEX_WIDTH)
  ) u_round_robin_arbiter (
    .request    (request_valid),
    .pointer    (pointer_q),
    .grant      (grant),
    .grant_index(grant_index),
    .grant_valid(grant_valid)
  );

  assign txn_type    = txn_type_t'(request_write[grant_index]);
  assign busy        = (state_q != S_IDLE);
  assign debug_state = state_q;

  // The oldest in-flight tag lines up with the data now on cam_table_read_data.
  assign scan_hit  = tag_valid_q[READ_LATENCY-1]
                     && (cam_table_read_data == mac_q)
                     && entry_valid_q[tag_addr_q[READ_LATENCY-1]];
  assign scan_last = tag_valid_q[READ_LATENCY-1]
                     && (tag_addr_q[READ_LATENCY-1] == ADDRESS_WIDTH'(TABLE_DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    request_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (!table_clear && grant_valid) begin
          accept        = 1'b1;
          request_ready = grant;
          state_d       = (txn_type == TXN_LEARN) ? S_WRITE : S_SCAN;
        end
      end
      S_WRITE:   state_d = S_RESPOND;
      S_SCAN:    if (scan_hit || scan_last) state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_q                  <= '0;
      owner_q                    <= '0;
      mac_q                      <= '0;
      entry_valid_q              <= '0;
      clear_pending_q            <= 1'b0;
      issuing_q                  <= 1'b0;
      tag_valid_q                <= '0;
      tag_addr_q                 <= '0;
      cam_table_read_address     <= '0;
      cam_table_write_address    <= '0;
      cam_table_write_data       <= '0;
      cam_table_write_data_valid <= 1'b0;
      response_valid             <= '0;
      response_hit               <= 1'b0;
      response_address           <= '0;
    end else begin
      cam_table_write_data_valid <= 1'b0;
      response_valid             <= '0;
      case (state_q)
        S_IDLE: begin
          if (table_clear) begin
            entry_valid_q <= '0;
          end else if (accept) begin
            pointer_q <= (grant_index == INDEX_WIDTH'(NUMBER_OF_REQUESTERS - 1))
                         ? '0 : grant_index + INDEX_WIDTH'(1);
            owner_q   <= grant;
            mac_q     <= request_mac[grant_index];
            if (txn_type == TXN_LEARN) begin
              cam_table_write_address    <= request_address[grant_index];
              cam_table_write_data       <= request_mac[grant_index];
              cam_table_write_data_valid <= (int'(request_address[grant_index]) < TABLE_DEPTH);
            end else begin
              cam_table_read_address <= '0;
              issuing_q              <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (table_clear) clear_pending_q <= 1'b1;
          response_valid   <= owner_q;
          response_hit     <= cam_table_write_data_valid;
          response_address <= cam_table_write_data_valid ? cam_table_write_address : '0;
          if (cam_table_write_data_valid) entry_valid_q[cam_table_write_address] <= 1'b1;
        end
        S_SCAN: begin
          if (table_clear) clear_pending_q <= 1'b1;
          tag_valid_q[0] <= issuing_q;
          tag_addr_q[0]  <= cam_table_read_address;
          for (int stage = 1; stage < READ_LATENCY; stage++) begin
            tag_valid_q[stage] <= tag_valid_q[stage-1];
            tag_addr_q[stage]  <= tag_addr_q[stage-1];
          end
          if (issuing_q) begin
            if (cam_table_read_address == ADDRESS_WIDTH'(TABLE_DEPTH - 1)) issuing_q <= 1'b0;
            else cam_table_read_address <= cam_table_read_address + ADDRESS_WIDTH'(1);
          end
          if (scan_hit || scan_last) begin
            response_valid   <= owner_q;
            response_hit     <= scan_hit;
            response_address <= scan_hit ? tag_addr_q[READ_LATENCY-1] : '0;
            tag_valid_q      <= '0;
            issuing_q        <= 1'b0;
          end
        end
        S_RESPOND: begin
          // A clear deferred during the transaction lands before the next arbitration.
          if (table_clear || clear_pending_q) begin
            entry_valid_q   <= '0;
            clear_pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
